div32x16_seq: RTL and testbench
===============================

# div32x16_seq

Iterative signed divider: 32-bit dividend by 16-bit divisor, producing a 16-bit quotient and a 16-bit remainder with overflow and divide-by-zero flagging. It is the inverse-direction companion of the DSP-tile 16x16 multiplier in the lock-in datapath. It normalises demodulated products (for example amplitude/reference and gain correction) without consuming a DSP tile. The block uses a start/done handshake, has a fixed latency, and processes one division at a time.

## Interface
- DW, 16, divisor/quotient/remainder width; dividend width is 2*DW.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- dividend  in  2*DW  signed dividend; captured with start.
- divisor  in  DW  signed divisor; captured with start.
- busy  out  1  high from the cycle after acceptance until done; reset 0.
- done  out  1  single-cycle pulse when results are valid; reset 0.
- quotient  out  DW  signed quotient, held until next done; reset 0.
- remainder  out  DW  signed remainder, held until next done; reset 0.
- ovf  out  1  quotient out of range or divisor==0, held with results; reset 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1, capture |dividend| (2*DW bits, unsigned; -2^31 maps to 0x80000000 correctly), |divisor|, both signs, and a zero-divisor flag.
  - Clear the partial remainder, load the iteration counter with 2*DW, set busy, go to RUN.
- RUN: one restoring-division step per cycle.
  - Shift in the next dividend MSB and trial-subtract the divisor magnitude.
  - Quotient bit = no-borrow.
  - Go to FIX after 2*DW steps.
- FIX:
  - Apply signs: quotient negated if the operand signs differ (truncation toward zero); remainder takes the dividend's sign.
  - Range-check the full 2*DW-bit signed quotient against [-2^(DW-1), 2^(DW-1)-1].
  - Register the outputs, pulse done, clear busy, return to IDLE.
- Overflow, no zero divisor: ovf=1; result per the configuration below. The remainder is always exact, since |r| < |divisor| ≤ 2^(DW-1).
- Zero divisor: ovf=1, remainder = dividend[DW-1:0]. The quotient follows the configuration below, and latency is unchanged.
- start while busy=1 is ignored; no queuing.
- rst at any time forces IDLE and zeroes all outputs. An in-flight division is discarded with no done.

## Timing
- start sampled high in cycle 0 → busy=1 in cycles 1..34, done=1 in cycle 34 only. Latency is 2*DW+2 = 34 cycles for every operand, including the zero and overflow cases.
- Outputs update in the same cycle done rises and stay stable until the next done or rst.
- Next start is accepted in cycle 34, i.e. the same cycle done=1, giving back-to-back throughput of one result per 34 cycles.
- done and busy are never high together after cycle 34.

## Configuration
- DIV_SATURATE_EN defined:
  - On overflow, quotient clamps to 0x7FFF (true quotient positive) or 0x8000 (negative).
  - On zero divisor, quotient = 0x7FFF if dividend ≥ 0, else 0x8000.
- DIV_SATURATE_EN undefined:
  - On overflow, quotient = low DW bits of the true two's-complement quotient (wrap).
  - On zero divisor, quotient = 0.
- ovf behaves identically in both builds.

## Structure
- Shared package lia_arith_pkg holds:
  - the state enum (IDLE/RUN/FIX);
  - DIV_DW = 16;
  - the saturation constants Q_MAX = 16'h7FFF and Q_MIN = 16'h8000.
- The iteration step (shift, trial subtract, quotient bit) is a natural sub-module, div_step, kept combinational.
- The sequencing FSM, registers and sign fix stay in div32x16_seq.

## Test plan
- 1000000 / 1000 → quotient=1000, remainder=0, ovf=0; done exactly in cycle 34 after start.
- -7 / 2 → quotient=0xFFFD (-3), remainder=0xFFFF (-1), ovf=0; and -65536 / 2 → quotient=0x8000, ovf=0 (boundary fits).
- 0x7FFFFFFF / 1 → ovf=1, remainder=0.
  - Without DIV_SATURATE_EN: quotient=0xFFFF.
  - With DIV_SATURATE_EN: quotient=0x7FFF.
- 0x80000000 / -1 → ovf=1.
  - Without DIV_SATURATE_EN: quotient=0x0000.
  - With DIV_SATURATE_EN: quotient=0x7FFF.
- 1234 / 0 → ovf=1, remainder=0x04D2.
  - Without DIV_SATURATE_EN: quotient=0.
  - With DIV_SATURATE_EN: quotient=0x7FFF.
  - Latency is still 34.
- Combined control sequence:
  - Start 100/3, then pulse start with 50/5 in cycle 5 → the second start is ignored.
  - Assert rst in cycle 10 → no done, all outputs 0.
  - Start 50/5 in cycle 12 → quotient=10, remainder=0, done in cycle 46.

Source files
------------

// File: rtl/lia_arith_pkg.sv
// Shared arithmetic definitions for the lock-in datapath: divider widths,
// FSM states and saturation limits.
package lia_arith_pkg;

  localparam int unsigned DIV_DW = 16;

  localparam logic [DIV_DW-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DIV_DW-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_e;

  // Two's-complement magnitude; -2^31 maps onto 0x80000000 as an unsigned value.
  function automatic logic [2*DIV_DW-1:0] abs_dvd(input logic [2*DIV_DW-1:0] x);
    return x[2*DIV_DW-1] ? -x : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when no borrow occurs.
module div_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] i_rem,
  input  logic          i_msb,
  input  logic [DW-1:0] i_dsr,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);

  logic [DW:0] w_shift;

  // The partial remainder stays below the divisor (<= 2^(DW-1)), so the
  // DW-bit modular difference is exact whenever the quotient bit is set.
  always_comb begin
    w_shift = {i_rem, i_msb};
    o_qbit  = (w_shift >= {1'b0, i_dsr});
    o_rem   = o_qbit ? (w_shift[DW-1:0] - i_dsr) : w_shift[DW-1:0];
  end

endmodule

// File: rtl/div32x16_seq.sv
// Iterative signed 32/16 divider, start/done handshake, fixed 34-cycle latency.
// Build option DIV_SATURATE_EN: saturate the quotient on overflow/zero divisor.
module div32x16_seq
  import lia_arith_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*DIV_DW-1:0]   dividend,
  input  logic [DIV_DW-1:0]     divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIV_DW-1:0]     quotient,
  output logic [DIV_DW-1:0]     remainder,
  output logic                  ovf
);

  localparam int unsigned DW    = DIV_DW;
  localparam int unsigned CW    = $clog2(2*DW+1);
  localparam logic [CW-1:0] STEPS = CW'(2*DW);
  localparam logic [2*DW-1:0] LIM_POS = {{DW{1'b0}}, Q_MAX};
  localparam logic [2*DW-1:0] LIM_NEG = {{DW{1'b0}}, Q_MIN};

  div_state_e r_state, w_next;

  logic [2*DW-1:0] r_dvd;
  logic [2*DW-1:0] r_quo;
  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_dsr;
  logic [DW-1:0]   r_dvd_lo;
  logic            r_sd, r_sv, r_zero;
  logic [CW-1:0]   r_cnt;

  logic            r_busy, r_done, r_ovf;
  logic [DW-1:0]   r_q, r_r;

  logic [DW-1:0]   w_rem_step;
  logic            w_qbit;
  logic            w_neg;
  logic [2*DW-1:0] w_q_sgn;
  logic            w_range_ovf;
  logic [DW-1:0]   w_q_fix, w_r_fix;
  logic            w_ovf_fix;

  div_step #(.DW(DW)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[2*DW-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_step),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == CW'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Range is judged on the unsigned magnitude so +2^31 is not mistaken for -2^31.
  always_comb begin
    w_neg       = r_sd ^ r_sv;
    w_q_sgn     = w_neg ? -r_quo : r_quo;
    w_range_ovf = w_neg ? (r_quo > LIM_NEG) : (r_quo > LIM_POS);
    w_ovf_fix   = r_zero | w_range_ovf;
    w_q_fix     = w_q_sgn[DW-1:0];
    w_r_fix     = r_sd ? -r_rem : r_rem;
`ifdef DIV_SATURATE_EN
    if (r_zero)
      w_q_fix = r_sd ? Q_MIN : Q_MAX;
    else if (w_range_ovf)
      w_q_fix = w_neg ? Q_MIN : Q_MAX;
`else
    if (r_zero)
      w_q_fix = '0;
`endif
    if (r_zero)
      w_r_fix = r_dvd_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dvd    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_dvd_lo <= '0;
      r_sd     <= 1'b0;
      r_sv     <= 1'b0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= start;
          if (start) begin
            r_dvd    <= abs_dvd(dividend);
            r_dsr    <= divisor[DW-1] ? -divisor : divisor;
            r_sd     <= dividend[2*DW-1];
            r_sv     <= divisor[DW-1];
            r_zero   <= (divisor == '0);
            r_dvd_lo <= dividend[DW-1:0];
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= STEPS;
          end
        end
        RUN: begin
          r_dvd <= {r_dvd[2*DW-2:0], 1'b0};
          r_quo <= {r_quo[2*DW-2:0], w_qbit};
          r_rem <= w_rem_step;
          r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_q    <= w_q_fix;
          r_r    <= w_r_fix;
          r_ovf  <= w_ovf_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div32x16_seq.sv
// Bench for div32x16_seq: transaction-level arithmetic model checked every cycle,
// plus directed vectors with literal expectations (honours DIV_SATURATE_EN).
`timescale 1ns/1ps
module tb_div32x16_seq;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, ovf;
  logic [15:0] quotient, remainder;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int ndone = 0;
  bit chk_en = 1'b0;

  div32x16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) ndone++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Arithmetic reference from signed integer division (truncating toward zero).
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic o);
    longint sa, sb, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      o = 1'b1;
      r = a[15:0];
`ifdef DIV_SATURATE_EN
      q = (sa < 0) ? 16'h8000 : 16'h7FFF;
`else
      q = 16'h0000;
`endif
    end else begin
      tq = sa / sb;
      tr = sa % sb;
      o  = (tq > 32767) || (tq < -32768);
      r  = tr[15:0];
      q  = tq[15:0];
`ifdef DIV_SATURATE_EN
      if (o) q = (tq > 0) ? 16'h7FFF : 16'h8000;
`endif
    end
  endtask

  // Cycle-accurate expectation: a job accepted at an edge is busy for LAT
  // cycles and publishes its result on the last of them.
  bit          m_active = 1'b0;
  bit          m_acc;
  int          m_age = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        p_o = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_age = 0; m_busy = 1'b0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_ovf = 1'b0;
    end else begin
      m_acc = start && (!m_active || m_age == LAT);
      if (m_active && m_age == LAT) m_active = 1'b0;
      if (m_acc) begin
        model(dividend, divisor, p_q, p_r, p_o);
        m_active = 1'b1;
        m_age    = 0;
      end
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == LAT) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_ovf = p_o;
        end
      end
      m_busy = m_active;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // b2b=1: caller sits at the negedge of a done cycle and issues start there.
  task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic eo,
                         input bit b2b, input string nm);
    int c0, n;
    bit seen;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; dividend = a; divisor = b; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 3*LAT) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({nm, "/done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "/latency"}, cyc - c0, LAT);
      chk({nm, "/q"}, quotient, eq);
      chk({nm, "/r"}, remainder, er);
      chk({nm, "/ovf"}, ovf, eo);
    end
  endtask

  logic [15:0] sq;
  int c0, nd0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/q", quotient, 0);
    chk("reset/r", remainder, 0);
    chk("reset/ovf", ovf, 0);

    run_div(32'd1000000, 16'd1000, 16'd1000, 16'd0, 1'b0, 1'b0, "1e6/1000");
    run_div(32'hFFFF_FFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, "-7/2");
    run_div(32'hFFFF_0000, 16'd2, 16'h8000, 16'h0000, 1'b0, 1'b0, "-65536/2");
    run_div(32'hFFF0_BDC0, 16'd1000, 16'hFC18, 16'h0000, 1'b0, 1'b0, "-1e6/1000");
    run_div(32'd12345, 16'hFF9C, 16'hFF85, 16'h002D, 1'b0, 1'b0, "12345/-100");
    run_div(32'hFFFF_CFC7, 16'hFF9C, 16'h007B, 16'hFFD3, 1'b0, 1'b0, "-12345/-100");
    run_div(32'hC000_8000, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, "max_pos_fit");
    run_div(32'h0000_8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0, "32768/-1");

`ifdef DIV_SATURATE_EN
    sq = 16'h7FFF;
`else
    sq = 16'hFFFF;
`endif
    run_div(32'h7FFF_FFFF, 16'd1, sq, 16'h0000, 1'b1, 1'b0, "7FFFFFFF/1");
`ifdef DIV_SATURATE_EN
    sq = 16'h7FFF;
`else
    sq = 16'h0000;
`endif
    run_div(32'h8000_0000, 16'hFFFF, sq, 16'h0000, 1'b1, 1'b0, "80000000/-1");
    run_div(32'h8000_0000, 16'h8000, sq, 16'h0000, 1'b1, 1'b0, "-2^31/-2^15");
`ifdef DIV_SATURATE_EN
    sq = 16'h7FFF;
`else
    sq = 16'h8000;
`endif
    run_div(32'h0000_8000, 16'd1, sq, 16'h0000, 1'b1, 1'b0, "32768/1");
`ifdef DIV_SATURATE_EN
    sq = 16'h7FFF;
`else
    sq = 16'h0000;
`endif
    run_div(32'd1234, 16'd0, sq, 16'h04D2, 1'b1, 1'b0, "1234/0");
`ifdef DIV_SATURATE_EN
    sq = 16'h8000;
`else
    sq = 16'h0000;
`endif
    run_div(32'hFFFF_FFFB, 16'd0, sq, 16'hFFFB, 1'b1, 1'b0, "-5/0");

    run_div(32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1, "b2b 100/7");
    run_div(32'd5, 16'd7, 16'd0, 16'd5, 1'b0, 1'b1, "b2b 5/7");

    // Ignored second start, reset mid-flight, then a clean restart.
    @(posedge clk); #1;
    c0 = cyc; nd0 = ndone;
    start = 1'b1; dividend = 32'd100; divisor = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    goto_cyc(c0 + 5);
    start = 1'b1; dividend = 32'd50; divisor = 16'd5;
    goto_cyc(c0 + 6);
    start = 1'b0;
    goto_cyc(c0 + 10);
    rst = 1'b1;
    goto_cyc(c0 + 11);
    rst = 1'b0;
    chk("ctl/no_done_before_rst", ndone - nd0, 0);
    @(negedge clk);
    chk("ctl/rst_busy", busy, 0);
    chk("ctl/rst_done", done, 0);
    chk("ctl/rst_q", quotient, 0);
    chk("ctl/rst_r", remainder, 0);
    chk("ctl/rst_ovf", ovf, 0);
    run_div(32'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, "ctl 50/5");
    chk("ctl/done_cycle", cyc - c0, 46);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    nerr++;
    $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
